// File: rtl/onchip_mem_stream_writer.sv
// onchip_mem_stream_writer
// Avalon-ST to Avalon-MM bridge that fills a 2**ADDR_W x DATA_W single-port
// on-chip RAM. Software programs START/LENGTH through the control slave and
// pulses GO. One word is written per cycle through a 2-entry skid buffer.
// When the buffer is empty, an incoming word bypasses it straight onto the
// memory outputs. This gives 1-cycle accept-to-write latency.
// Optional feature macro: ONCHIP_MEM_STREAM_WRITER_ABORT_EN (CONTROL bit2 = ABORT).
//
// state | meaning
// IDLE  | waiting for GO, snk_ready low
// RUN   | accepting stream words, writing one per cycle
// DONE  | single cycle: set done, return to IDLE
module onchip_mem_stream_writer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 13
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            ctl_address,
   input  logic                  ctl_write,
   input  logic                  ctl_read,
   input  logic [31:0]           ctl_writedata,
   output logic [31:0]           ctl_readdata,
   input  logic [DATA_W-1:0]     snk_data,
   input  logic                  snk_valid,
   input  logic                  snk_endofpacket,
   output logic                  snk_ready,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   output logic                  irq
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   start_reg;
   logic [ADDR_W-1:0]   addr_ptr;
   logic [CNT_W-1:0]    length_reg;
   logic [CNT_W-1:0]    remaining;
   logic [CNT_W-1:0]    words_written;
   logic                irq_en;
   logic                done;
   logic                eop_early;
   logic                aborted;

   logic [DATA_W-1:0]   buf_data [2];
   logic [1:0]          buf_eop;
   logic [1:0]          buf_cnt;
   logic                buf_head;

   logic                run;
   logic                buf_empty;
   logic                accept;
   logic                write_now;
   logic                last_word;
   logic                abort_req;
   logic                push;
   logic                pop;
   logic                flush;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_eop;
   logic                wr_start;
   logic                wr_length;
   logic                wr_control;
   logic                wr_status;
   logic                go;
   logic [31:0]         status_word;
   logic                unused_wdata;

   assign run        = (state == S_RUN);
   assign buf_empty  = (buf_cnt == 2'd0);
   assign snk_ready  = run && (buf_cnt != 2'd2);
   assign accept     = snk_valid && snk_ready;

   // The head of the buffer has priority; an empty buffer lets the stream bypass it.
   assign wr_data    = buf_empty ? snk_data : buf_data[buf_head];
   assign wr_eop     = buf_empty ? snk_endofpacket : buf_eop[buf_head];
   assign write_now  = run && !abort_req && (!buf_empty || accept);
   assign last_word  = write_now && ((remaining == CNT_W'(1)) || wr_eop);
   assign push       = accept && !buf_empty;
   assign pop        = write_now && !buf_empty;
   assign flush      = !run || last_word || abort_req;

   assign wr_start   = ctl_write && (ctl_address == 2'd0);
   assign wr_length  = ctl_write && (ctl_address == 2'd1);
   assign wr_control = ctl_write && (ctl_address == 2'd2);
   assign wr_status  = ctl_write && (ctl_address == 2'd3);
   assign go         = wr_control && ctl_writedata[0] && (state == S_IDLE);

   assign mem_byteenable = '1;
   assign mem_clken      = 1'b1;
   assign irq            = done && irq_en;
   assign unused_wdata   = &{1'b0, ctl_writedata[31:CNT_W]};

`ifdef ONCHIP_MEM_STREAM_WRITER_ABORT_EN
   assign abort_req = wr_control && ctl_writedata[2] && run;

   // aborted flag: cleared by GO, set by an ABORT pulse while running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aborted <= 1'b0;
      end else if (go) begin
         aborted <= 1'b0;
      end else if (abort_req) begin
         aborted <= 1'b1;
      end
   end
`else
   assign abort_req = 1'b0;
   assign aborted   = 1'b0;
`endif

   // Software-visible configuration; START/LENGTH are frozen while running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_reg  <= '0;
         length_reg <= '0;
         irq_en     <= 1'b0;
      end else begin
         if (wr_start && !run) begin
            start_reg <= ctl_writedata[ADDR_W-1:0];
         end
         if (wr_length && !run) begin
            length_reg <= ctl_writedata[CNT_W-1:0];
         end
         if (wr_control) begin
            irq_en <= ctl_writedata[1];
         end
      end
   end

   // Two-entry skid buffer; emptied whenever the transfer ends or is not running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_data[0] <= '0;
         buf_data[1] <= '0;
         buf_eop     <= '0;
         buf_cnt     <= 2'd0;
         buf_head    <= 1'b0;
      end else if (flush) begin
         buf_cnt  <= 2'd0;
         buf_head <= 1'b0;
      end else begin
         if (push) begin
            buf_data[buf_head ^ buf_cnt[0]] <= snk_data;
            buf_eop[buf_head ^ buf_cnt[0]]  <= snk_endofpacket;
         end
         buf_cnt  <= buf_cnt + {1'b0, push} - {1'b0, pop};
         buf_head <= buf_head ^ pop;
      end
   end

   // Transfer FSM with registered memory-side outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         addr_ptr       <= '0;
         remaining      <= '0;
         words_written  <= '0;
         done           <= 1'b0;
         eop_early      <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
      end else begin
         mem_chipselect <= write_now;
         mem_write      <= write_now;
         if (write_now) begin
            mem_address   <= addr_ptr;
            mem_writedata <= wr_data;
         end
         if (wr_status && ctl_writedata[1]) begin
            done <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (go) begin
                  addr_ptr      <= start_reg;
                  remaining     <= length_reg;
                  words_written <= '0;
                  eop_early     <= 1'b0;
                  done          <= 1'b0;
                  state         <= (length_reg == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (write_now) begin
                  addr_ptr      <= addr_ptr + ADDR_W'(1);
                  remaining     <= remaining - CNT_W'(1);
                  words_written <= words_written + CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state <= S_DONE;
                  end else if (wr_eop) begin
                     eop_early <= 1'b1;
                     state     <= S_DONE;
                  end
               end
               if (abort_req) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // STATUS word assembly
   always_comb begin
      status_word             = '0;
      status_word[0]          = run;
      status_word[1]          = done;
      status_word[2]          = eop_early;
      status_word[3]          = aborted;
      status_word[16 +: CNT_W] = words_written;
   end

   // Registered control read port; holds its value between reads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctl_readdata <= '0;
      end else if (ctl_read) begin
         case (ctl_address)
            2'd0:    ctl_readdata <= 32'(start_reg);
            2'd1:    ctl_readdata <= 32'(length_reg);
            2'd2:    ctl_readdata <= {30'd0, irq_en, 1'b0};
            default: ctl_readdata <= status_word;
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_stream_writer.sv
`timescale 1ns/1ps
module tb_onchip_mem_stream_writer;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 13;
`ifdef ONCHIP_MEM_STREAM_WRITER_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [1:0]          ctl_address = '0;
   logic                ctl_write = 1'b0;
   logic                ctl_read = 1'b0;
   logic [31:0]         ctl_writedata = '0;
   logic [31:0]         ctl_readdata;
   logic [DATA_W-1:0]   snk_data = '0;
   logic                snk_valid = 1'b0;
   logic                snk_endofpacket = 1'b0;
   logic                snk_ready;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic [DATA_W-1:0]   mem_writedata;
   logic                mem_clken;
   logic                irq;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   onchip_mem_stream_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .ctl_address(ctl_address), .ctl_write(ctl_write), .ctl_read(ctl_read),
      .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_endofpacket(snk_endofpacket),
      .snk_ready(snk_ready),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken), .irq(irq)
   );

   // kind: 0 plain, 1 START write + GO while busy, 2 ABORT, 3 reset mid-run
   typedef struct {
      logic [11:0] start;
      int          len;
      int          eop_idx;
      int          vmode;
      int          kind;
      int          inj_after;
      logic [31:0] base;
      int          exp_n;
      bit          exp_eop;
      logic [11:0] exp_last;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
      @(negedge clk);
      ctl_write = 1'b0;
   endtask

   task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      ctl_address = a; ctl_read = 1'b1;
      @(negedge clk);
      ctl_read = 1'b0;
      d = ctl_readdata;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " snk_ready"}, 32'(snk_ready), 32'd0);
      check({tag, " mem_write"}, 32'(mem_write), 32'd0);
      check({tag, " mem_cs"}, 32'(mem_chipselect), 32'd0);
      check({tag, " mem_address"}, 32'(mem_address), 32'd0);
      check({tag, " mem_writedata"}, mem_writedata, 32'd0);
      check({tag, " irq"}, 32'(irq), 32'd0);
      check({tag, " ctl_readdata"}, ctl_readdata, 32'd0);
      check({tag, " byteenable"}, 32'(mem_byteenable), 32'hF);
      check({tag, " clken"}, 32'(mem_clken), 32'd1);
   endtask

   task automatic run_xfer(input vec_t v, input string tag);
      logic [31:0] words [$];
      bit          eops [$];
      int          acc_cyc [$];
      logic [11:0] wa [$];
      logic [31:0] wd [$];
      int          wc [$];
      int          idx = 0;
      int          m_n;
      int          n_obs;
      int          stage = 0;
      int          nw;
      bit          was_reset = 1'b0;
      bit          exp_eop;
      bit          exp_abort = 1'b0;
      logic [31:0] rd;

      nw = v.len + 2;
      for (int i = 0; i < nw; i++) begin
         words.push_back((v.base != 0) ? v.base + 32'(i) : $urandom);
         eops.push_back(v.eop_idx == i + 1);
      end
      // reference: first eop inside the length ends the packet early
      m_n = v.len;
      for (int i = 0; i < v.len; i++) begin
         if (eops[i]) begin
            m_n = i + 1;
            break;
         end
      end
      exp_eop = (m_n < v.len);

      ctl_wr(2'd0, 32'(v.start));
      ctl_wr(2'd1, 32'(v.len));
      ctl_wr(2'd2, 32'h3);

      for (int c = 0; c < 4 * v.len + 20; c++) begin
         @(negedge clk);
         if (mem_write) begin
            wa.push_back(mem_address);
            wd.push_back(mem_writedata);
            wc.push_back(c);
         end
         ctl_write = 1'b0;
         if (stage == 1) begin
            ctl_address = 2'd2; ctl_writedata = 32'h3; ctl_write = 1'b1;
            stage = 2;
         end else if (v.kind != 0 && stage == 0 && wa.size() == v.inj_after) begin
            stage = 2;
            if (v.kind == 1) begin
               ctl_address = 2'd0; ctl_writedata = 32'h555; ctl_write = 1'b1;
               stage = 1;
            end else if (v.kind == 2) begin
               ctl_address = 2'd2; ctl_writedata = 32'h6; ctl_write = 1'b1;
            end else begin
               #1 reset_n = 1'b0;
               was_reset = 1'b1;
               break;
            end
         end
         if (idx < nw) begin
            snk_data = words[idx];
            snk_endofpacket = eops[idx];
            case (v.vmode)
               0:       snk_valid = 1'b1;
               1:       snk_valid = ((c % 2) == 1);
               default: snk_valid = 1'($urandom_range(0, 1));
            endcase
         end else begin
            snk_valid = 1'b0;
         end
         if (snk_valid && snk_ready) begin
            acc_cyc.push_back(c);
            idx++;
         end
      end
      ctl_write = 1'b0;
      n_obs = wa.size();

      if (was_reset) begin
         #1;
         check_reset_outputs({tag, " async"});
         check({tag, " writes before reset"}, 32'(n_obs), 32'(v.inj_after));
         snk_valid = 1'b0;
         snk_endofpacket = 1'b0;
         repeat (2) begin
            @(negedge clk);
            check({tag, " no write in reset"}, 32'(mem_write), 32'd0);
         end
         reset_n = 1'b1;
         ctl_rd(2'd3, rd);
         check({tag, " status after reset"}, rd, 32'd0);
         ctl_rd(2'd0, rd);
         check({tag, " start after reset"}, rd, 32'd0);
         return;
      end
      snk_valid = 1'b0;
      snk_endofpacket = 1'b0;

      if (v.kind == 2 && ABORT_EN) begin
         check({tag, " abort write count 2..3"}, 32'(n_obs >= 2 && n_obs <= 3), 32'd1);
         m_n = n_obs;
         exp_eop = 1'b0;
         exp_abort = 1'b1;
      end else begin
         check({tag, " write count"}, 32'(n_obs), 32'(m_n));
      end
      if (v.exp_n >= 0) begin
         check({tag, " table count"}, 32'(n_obs), 32'(v.exp_n));
         check({tag, " table eop_early"}, 32'(exp_eop), 32'(v.exp_eop));
         if (n_obs > 0) check({tag, " last address"}, 32'(wa[n_obs-1]), 32'(v.exp_last));
      end
      for (int i = 0; i < n_obs && i < nw; i++) begin
         check($sformatf("%s addr[%0d]", tag, i), 32'(wa[i]), 32'((int'(v.start) + i) % 4096));
         check($sformatf("%s data[%0d]", tag, i), wd[i], words[i]);
         if (i < acc_cyc.size())
            check($sformatf("%s latency[%0d]", tag, i), 32'(wc[i] - acc_cyc[i]), 32'd1);
      end
      check({tag, " ready low after"}, 32'(snk_ready), 32'd0);
      ctl_rd(2'd3, rd);
      check({tag, " busy"}, 32'(rd[0]), 32'd0);
      check({tag, " done"}, 32'(rd[1]), 32'd1);
      check({tag, " eop_early"}, 32'(rd[2]), 32'(exp_eop));
      check({tag, " aborted"}, 32'(rd[3]), 32'(exp_abort));
      check({tag, " words_written"}, 32'(rd[28:16]), 32'(m_n));
      check({tag, " irq set"}, 32'(irq), 32'd1);
      if (v.kind == 1) begin
         ctl_rd(2'd0, rd);
         check({tag, " start unchanged"}, rd, 32'(v.start));
      end
      ctl_wr(2'd3, 32'h2);
      check({tag, " irq cleared"}, 32'(irq), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      vec_t        rv;
      int          first_irq;
      int          zero_wr;

      tbl[0] = '{12'h010, 4,  0, 0, 0, 0, 32'hA0, 4,  1'b0, 12'h013};
      tbl[1] = '{12'hFFE, 4,  0, 1, 0, 0, 32'hB0, 4,  1'b0, 12'h001};
      tbl[2] = '{12'h100, 8,  3, 0, 0, 0, 32'hC0, 3,  1'b1, 12'h102};
      tbl[3] = '{12'h7F0, 5,  5, 2, 0, 0, 32'h0,  5,  1'b0, 12'h7F4};
      tbl[4] = '{12'h020, 16, 0, 0, 1, 3, 32'h0,  16, 1'b0, 12'h02F};
      tbl[5] = '{12'h300, 10, 0, 0, 2, 2, 32'h0,  -1, 1'b0, 12'h000};
      tbl[6] = '{12'h200, 10, 0, 0, 3, 5, 32'h0,  -1, 1'b0, 12'h000};

      #2;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         ctl_rd(2'(a), rd);
         check($sformatf("reset reg%0d", a), rd, 32'd0);
      end

      for (int t = 0; t < 7; t++) run_xfer(tbl[t], $sformatf("vec%0d", t));

      // readdata holds between reads
      ctl_wr(2'd0, 32'h123);
      ctl_rd(2'd0, rd);
      check("read start", rd, 32'h123);
      ctl_wr(2'd1, 32'h7);
      repeat (2) @(negedge clk);
      check("readdata holds", ctl_readdata, 32'h123);

      // zero length: done within 2 cycles, no memory write
      ctl_wr(2'd0, 32'h040);
      ctl_wr(2'd1, 32'h0);
      ctl_wr(2'd2, 32'h3);
      first_irq = 99;
      zero_wr = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mem_write) zero_wr++;
         if (irq && first_irq == 99) first_irq = c;
      end
      check("zero-len writes", 32'(zero_wr), 32'd0);
      check("zero-len done in 2", 32'(first_irq <= 1), 32'd1);
      ctl_rd(2'd3, rd);
      check("zero-len status", rd, 32'h2);
      ctl_wr(2'd3, 32'h2);

      for (int t = 0; t < 6; t++) begin
         rv.start     = 12'($urandom_range(0, 4095));
         rv.len       = $urandom_range(1, 12);
         rv.eop_idx   = $urandom_range(0, rv.len + 1);
         rv.vmode     = $urandom_range(0, 2);
         rv.kind      = 0;
         rv.inj_after = 0;
         rv.base      = 32'h0;
         rv.exp_n     = -1;
         rv.exp_eop   = 1'b0;
         rv.exp_last  = 12'h0;
         run_xfer(rv, $sformatf("rnd%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
